// File: rtl/gigatron_video_out.sv
// Gigatron OUT/XOUT port: registered VGA pins, LED latch, frame counter
// and hsync line-period monitor.
module gigatron_video_out #(
  parameter int unsigned LINE_MIN = 190,
  parameter int unsigned LINE_MAX = 210,
  parameter int unsigned CNT_W    = 12
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Out_Write,
  input  logic [7:0] i_Out_Data,
  input  logic [7:0] i_Acc,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic [2:0] o_VGA_Red,
  output logic [2:0] o_VGA_Grn,
  output logic [2:0] o_VGA_Blu,
  output logic [7:0] o_Xout,
  output logic [7:0] o_Frame_Count,
  output logic       o_Line_Ok
);

  // One extra bit so line_cnt+1 cannot wrap when the counter is saturated.
  localparam int unsigned PER_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0] OUT_IDLE = 8'hC0;

  logic [7:0]       out_reg;
  logic [CNT_W-1:0] line_cnt;
  logic             armed;

  logic             h_rise_c;
  logic             h_fall_c;
  logic             v_fall_c;
  logic [PER_W-1:0] period_c;
  logic             period_ok_c;
  logic             blank_c;

  // 2-bit colour to 3-bit pin value, replicating the MSB into the LSB.
  function automatic logic [2:0] expand(input logic [1:0] c);
    return {c[1], c[0], c[1]};
  endfunction

  // Sync edges from old OUT value against the byte being written.
  always_comb begin
    h_rise_c    = 1'b0;
    h_fall_c    = 1'b0;
    v_fall_c    = 1'b0;
    if (i_Out_Write) begin
      h_rise_c = !out_reg[6] &&  i_Out_Data[6];
      h_fall_c =  out_reg[6] && !i_Out_Data[6];
      v_fall_c =  out_reg[7] && !i_Out_Data[7];
    end
    period_c    = PER_W'(line_cnt) + PER_W'(1);
    period_ok_c = (period_c >= PER_W'(LINE_MIN)) && (period_c <= PER_W'(LINE_MAX));
    blank_c     = !out_reg[6] || !out_reg[7];
  end

  // OUT register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      out_reg <= OUT_IDLE;
    end else if (i_Out_Write) begin
      out_reg <= i_Out_Data;
    end
  end

  // VGA pins, one clock behind out_reg so syncs and colours stay aligned.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_VGA_HSync <= 1'b1;
      o_VGA_VSync <= 1'b1;
      o_VGA_Red   <= 3'd0;
      o_VGA_Grn   <= 3'd0;
      o_VGA_Blu   <= 3'd0;
    end else begin
      o_VGA_HSync <= out_reg[6];
      o_VGA_VSync <= out_reg[7];
      o_VGA_Red   <= blank_c ? 3'd0 : expand(out_reg[1:0]);
      o_VGA_Grn   <= blank_c ? 3'd0 : expand(out_reg[3:2]);
      o_VGA_Blu   <= blank_c ? 3'd0 : expand(out_reg[5:4]);
    end
  end

  // XOUT latch samples the accumulator on hsync rise.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Xout <= 8'h00;
    end else if (h_rise_c) begin
      o_Xout <= i_Acc;
    end
  end

  // Frame counter on vsync fall, wraps mod 256.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Frame_Count <= 8'd0;
    end else if (v_fall_c) begin
      o_Frame_Count <= o_Frame_Count + 8'd1;
    end
  end

  // Line monitor: judge period on each armed hsync fall, flag a stalled sync.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      line_cnt  <= '0;
      armed     <= 1'b0;
      o_Line_Ok <= 1'b0;
    end else begin
      if (line_cnt != CNT_MAX) begin
        line_cnt <= line_cnt + CNT_W'(1);
      end
      if (h_fall_c) begin
        if (armed) begin
          o_Line_Ok <= period_ok_c;
        end
        line_cnt <= '0;
        armed    <= 1'b1;
      end else if (line_cnt == CNT_MAX) begin
        o_Line_Ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gigatron_video_out.sv
// Directed bench for gigatron_video_out: inputs change and outputs are
// sampled on the falling clock edge.
module tb_gigatron_video_out;

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b0;
  logic       i_Out_Write = 1'b0;
  logic [7:0] i_Out_Data = 8'hC0;
  logic [7:0] i_Acc = 8'h00;
  logic       o_VGA_HSync;
  logic       o_VGA_VSync;
  logic [2:0] o_VGA_Red;
  logic [2:0] o_VGA_Grn;
  logic [2:0] o_VGA_Blu;
  logic [7:0] o_Xout;
  logic [7:0] o_Frame_Count;
  logic       o_Line_Ok;

  int errors = 0;
  int checks = 0;

  gigatron_video_out #(.LINE_MIN(190), .LINE_MAX(210), .CNT_W(12)) dut (
    .i_Clk(i_Clk),
    .i_Reset(i_Reset),
    .i_Out_Write(i_Out_Write),
    .i_Out_Data(i_Out_Data),
    .i_Acc(i_Acc),
    .o_VGA_HSync(o_VGA_HSync),
    .o_VGA_VSync(o_VGA_VSync),
    .o_VGA_Red(o_VGA_Red),
    .o_VGA_Grn(o_VGA_Grn),
    .o_VGA_Blu(o_VGA_Blu),
    .o_Xout(o_Xout),
    .o_Frame_Count(o_Frame_Count),
    .o_Line_Ok(o_Line_Ok)
  );

  always #5 i_Clk = ~i_Clk;

  // Apply inputs at a falling edge and consume exactly one rising edge.
  task automatic step(input logic w, input logic [7:0] d, input logic [7:0] a);
    i_Out_Write = w;
    i_Out_Data  = d;
    i_Acc       = a;
    @(negedge i_Clk);
    i_Out_Write = 1'b0;
  endtask

  task automatic do_reset(input logic w, input logic [7:0] d);
    i_Reset = 1'b1;
    step(w, d, 8'hEE);
    i_Reset = 1'b0;
  endtask

  // Hsync fall edge (0xC0 -> 0x80).
  task automatic hfall();
    step(1'b1, 8'h80, 8'h00);
  endtask

  // Remainder of a line so the next hfall lands exactly 'period' edges later.
  task automatic hrest(input int period);
    step(1'b1, 8'hC0, 8'h00);
    repeat (period - 2) step(1'b0, 8'hC0, 8'h00);
  endtask

  task automatic check_ok(input string name, input logic exp);
    checks++;
    if (o_Line_Ok !== exp) begin
      errors++;
      $display("FAIL %s: line_ok=%b expected %b", name, o_Line_Ok, exp);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0, 8'hC0);
    repeat (10) step(1'b0, 8'hC0, 8'h00);
    checks++; if (o_VGA_HSync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", o_VGA_HSync); end
    checks++; if (o_VGA_VSync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", o_VGA_VSync); end
    checks++; if ({o_VGA_Red, o_VGA_Grn, o_VGA_Blu} !== 9'd0) begin errors++; $display("FAIL reset_rgb: got %b/%b/%b expected 000/000/000", o_VGA_Red, o_VGA_Grn, o_VGA_Blu); end
    checks++; if (o_Xout !== 8'h00) begin errors++; $display("FAIL reset_xout: got %h expected 00", o_Xout); end
    checks++; if (o_Frame_Count !== 8'd0) begin errors++; $display("FAIL reset_frame: got %0d expected 0", o_Frame_Count); end
    check_ok("reset_line_ok", 1'b0);
  endtask

  task automatic test_colour();
    // 0xE4: red=00 green=01 blue=10, syncs high
    step(1'b1, 8'hE4, 8'h00);
    checks++; if (o_VGA_Grn !== 3'b000) begin errors++; $display("FAIL colour_latency: grn=%b expected 000", o_VGA_Grn); end
    step(1'b0, 8'hE4, 8'h00);
    checks++; if (o_VGA_Red !== 3'b000) begin errors++; $display("FAIL colour_red: got %b expected 000", o_VGA_Red); end
    checks++; if (o_VGA_Grn !== 3'b010) begin errors++; $display("FAIL colour_grn: got %b expected 010", o_VGA_Grn); end
    checks++; if (o_VGA_Blu !== 3'b101) begin errors++; $display("FAIL colour_blu: got %b expected 101", o_VGA_Blu); end
    // 0xA4: hsync low, blanked
    step(1'b1, 8'hA4, 8'h00);
    step(1'b0, 8'hA4, 8'h00);
    checks++; if (o_VGA_HSync !== 1'b0) begin errors++; $display("FAIL blank_hsync: got %b expected 0", o_VGA_HSync); end
    checks++; if ({o_VGA_Red, o_VGA_Grn, o_VGA_Blu} !== 9'd0) begin errors++; $display("FAIL blank_rgb: got %b/%b/%b expected 000/000/000", o_VGA_Red, o_VGA_Grn, o_VGA_Blu); end
    // 0x7F: vsync low also blanks
    step(1'b1, 8'h7F, 8'h00);
    step(1'b0, 8'h7F, 8'h00);
    checks++; if (o_VGA_VSync !== 1'b0 || o_VGA_Red !== 3'b000) begin errors++; $display("FAIL vblank: vsync=%b red=%b expected 0/000", o_VGA_VSync, o_VGA_Red); end
    step(1'b1, 8'hC0, 8'h00);
  endtask

  task automatic test_xout();
    step(1'b1, 8'h80, 8'h5A);
    checks++; if (o_Xout !== 8'h00) begin errors++; $display("FAIL xout_on_fall: got %h expected 00", o_Xout); end
    step(1'b1, 8'hC0, 8'h5A);
    checks++; if (o_Xout !== 8'h5A) begin errors++; $display("FAIL xout_rise: got %h expected 5a", o_Xout); end
    step(1'b1, 8'hC0, 8'h33);
    checks++; if (o_Xout !== 8'h5A) begin errors++; $display("FAIL xout_no_edge: got %h expected 5a", o_Xout); end
  endtask

  task automatic test_line();
    do_reset(1'b0, 8'hC0);
    hfall();      check_ok("line_first_arm", 1'b0);
    hrest(200); hfall(); check_ok("line_200a", 1'b1);
    hrest(200); hfall(); check_ok("line_200b", 1'b1);
    hrest(180); hfall(); check_ok("line_180", 1'b0);
    hrest(215); hfall(); check_ok("line_215", 1'b0);
    hrest(190); hfall(); check_ok("line_190_min", 1'b1);
    hrest(189); hfall(); check_ok("line_189", 1'b0);
    hrest(210); hfall(); check_ok("line_210_max", 1'b1);
    hrest(211); hfall(); check_ok("line_211", 1'b0);
    hrest(200); hfall(); check_ok("line_recover", 1'b1);
    // counter reaches 4095 after 4095 edges; flag drops on the next edge
    step(1'b1, 8'hC0, 8'h00);
    repeat (4094) step(1'b0, 8'hC0, 8'h00);
    check_ok("line_presat", 1'b1);
    step(1'b0, 8'hC0, 8'h00);
    check_ok("line_stall", 1'b0);
    hfall(); check_ok("line_after_stall", 1'b0);
    hrest(200); hfall(); check_ok("line_after_stall_200", 1'b1);
  endtask

  task automatic test_frame();
    do_reset(1'b0, 8'hC0);
    for (int i = 1; i <= 257; i++) begin
      step(1'b1, 8'h40, 8'h00);
      if (i == 1 || i == 255 || i == 256 || i == 257) begin
        checks++;
        if (o_Frame_Count !== 8'(i)) begin
          errors++;
          $display("FAIL frame_%0d: got %0d expected %0d", i, o_Frame_Count, 8'(i));
        end
      end
      step(1'b1, 8'hC0, 8'h00);
    end
    checks++; if (o_Frame_Count !== 8'd1) begin errors++; $display("FAIL frame_rise_hold: got %0d expected 1", o_Frame_Count); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'hC1, 8'h00);
    step(1'b1, 8'hC2, 8'h00);
    checks++; if (o_VGA_Red !== 3'b010) begin errors++; $display("FAIL b2b_c1: red=%b expected 010", o_VGA_Red); end
    step(1'b1, 8'hC3, 8'h00);
    checks++; if (o_VGA_Red !== 3'b101) begin errors++; $display("FAIL b2b_c2: red=%b expected 101", o_VGA_Red); end
    step(1'b0, 8'hC3, 8'h00);
    checks++; if (o_VGA_Red !== 3'b111) begin errors++; $display("FAIL b2b_c3: red=%b expected 111", o_VGA_Red); end
    // combined hsync+vsync fall: counts a frame and arms the monitor
    step(1'b1, 8'h00, 8'h00);
    checks++; if (o_Frame_Count !== 8'd2) begin errors++; $display("FAIL both_fall_frame: got %0d expected 2", o_Frame_Count); end
    check_ok("both_fall_arm_only", 1'b0);
    hrest(200); hfall(); check_ok("both_fall_then_200", 1'b1);
  endtask

  task automatic test_midline_reset();
    repeat (100) step(1'b0, 8'h80, 8'h00);
    // reset while a write of 0x00 is presented: reset must win
    do_reset(1'b1, 8'h00);
    step(1'b0, 8'hC0, 8'h00);
    checks++; if (o_VGA_HSync !== 1'b1 || o_VGA_VSync !== 1'b1) begin errors++; $display("FAIL reset_over_write: hs=%b vs=%b expected 1/1", o_VGA_HSync, o_VGA_VSync); end
    checks++; if (o_Frame_Count !== 8'd0) begin errors++; $display("FAIL midreset_frame: got %0d expected 0", o_Frame_Count); end
    check_ok("midreset_cleared", 1'b0);
    repeat (97) step(1'b0, 8'hC0, 8'h00);
    hfall(); check_ok("midreset_first_fall", 1'b0);
    hrest(200); hfall(); check_ok("midreset_200", 1'b1);
  endtask

  initial begin
    @(negedge i_Clk);
    test_reset();
    test_colour();
    test_xout();
    test_line();
    test_frame();
    test_back_to_back();
    test_midline_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
